// File: rtl/dpe_mvm_sched.sv
// dpe_mvm_sched: walks rows x chunks through one DPE, accumulates rows into an output FIFO; define DPE_SCHED_RELU_EN to clamp negative row results
module dpe_mvm_sched #(
  parameter int DATAW = 512,
  parameter int OPREC = 32,
  parameter int DPE_LAT = 8,
  parameter int ROWW = 9,
  parameter int CHUNKW = 4,
  parameter int WADDRW = 13,
  parameter int OFIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ROWW-1:0]   cmd_rows,
  input  logic [CHUNKW-1:0] cmd_chunks,
  input  logic [WADDRW-1:0] cmd_wbase,
  output logic              w_rden,
  output logic [WADDRW-1:0] w_raddr,
  input  logic [DATAW-1:0]  w_rdata,
  output logic              v_rden,
  output logic [CHUNKW-1:0] v_raddr,
  input  logic [DATAW-1:0]  v_rdata,
  output logic              dpe_valid,
  output logic [DATAW-1:0]  dpe_dataa,
  output logic [DATAW-1:0]  dpe_datab,
  input  logic              dpe_ovalid,
  input  logic [OPREC-1:0]  dpe_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OPREC-1:0]  res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done
);
  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam int CRW = $clog2(OFIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ROWW-1:0] rows, r;
  logic [CHUNKW-1:0] chunks, c;
  logic [WADDRW-1:0] waddr;
  logic [CRW-1:0] credits;
  logic [DPE_LAT:0][2:0] fpipe;
  logic [OPREC-1:0] acc, acc_next, push_data;
  logic [OPREC:0] fifo [OFIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic c_first, c_last, r_last, issue, push, pop;
  assign c_first = c == '0;
  assign c_last = c == chunks - CHUNKW'(1);
  assign r_last = r == rows - ROWW'(1);
  // a new row needs a reserved FIFO slot; later chunks of that row ride on it
  assign issue = state == RUN && (!c_first || credits != '0);
  assign push = dpe_ovalid && fpipe[DPE_LAT][1];
  assign pop = res_valid && res_ready;
  assign acc_next = fpipe[DPE_LAT][2] ? dpe_result : acc + dpe_result;
`ifdef DPE_SCHED_RELU_EN
  assign push_data = acc_next[OPREC-1] ? '0 : acc_next;
`else
  assign push_data = acc_next;
`endif
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign w_rden = issue;
  assign v_rden = issue;
  assign w_raddr = waddr;
  assign v_raddr = c;
  assign dpe_dataa = w_rdata;
  assign dpe_datab = v_rdata;
  assign res_valid = wp != rp;
  assign {res_last, res_data} = fifo[rp[AW-1:0]];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (cmd_valid) state_n = (cmd_rows == '0 || cmd_chunks == '0) ? DONE : RUN;
      RUN:   if (issue && c_last && r_last) state_n = DRAIN;
      DRAIN: if (push && fpipe[DPE_LAT][0]) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rows <= '0;
      chunks <= '0;
      r <= '0;
      c <= '0;
      waddr <= '0;
      credits <= CRW'(OFIFO_DEPTH);
      fpipe <= '0;
      dpe_valid <= 1'b0;
      acc <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_n;
      if (cmd_valid && state == IDLE) begin
        rows <= cmd_rows;
        chunks <= cmd_chunks;
        waddr <= cmd_wbase;
        r <= '0;
        c <= '0;
      end else if (issue) begin
        waddr <= waddr + WADDRW'(1);
        c <= c_last ? '0 : c + CHUNKW'(1);
        r <= c_last ? r + ROWW'(1) : r;
      end
      credits <= credits - CRW'(issue && c_first) + CRW'(pop);
      fpipe <= {fpipe[DPE_LAT-1:0], issue ? {c_first, c_last, c_last && r_last} : 3'b000};
      dpe_valid <= issue;
      if (dpe_ovalid) acc <= acc_next;
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wp[AW-1:0]] <= {fpipe[DPE_LAT][0], push_data};
  end
endmodule

// File: tb/tb_dpe_mvm_sched.sv
// tb_dpe_mvm_sched: directed tests of dpe_mvm_sched with memory and DPE stand-ins and a row-result model
module tb_dpe_mvm_sched;
  localparam int DATAW = 512, OPREC = 32, DPE_LAT = 8, ROWW = 9, CHUNKW = 4, WADDRW = 13, OFIFO_DEPTH = 16;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [ROWW-1:0] cmd_rows = '0;
  logic [CHUNKW-1:0] cmd_chunks = '0;
  logic [WADDRW-1:0] cmd_wbase = '0;
  logic w_rden, v_rden, dpe_valid, dpe_ovalid, res_valid, res_last, busy, done;
  logic res_ready = 1;
  logic [WADDRW-1:0] w_raddr;
  logic [CHUNKW-1:0] v_raddr;
  logic [DATAW-1:0] w_rdata, v_rdata, dpe_dataa, dpe_datab;
  logic [OPREC-1:0] dpe_result, res_data, lastres;
  logic [OPREC:0] dpipe [DPE_LAT];
  logic [OPREC:0] expq [$];
  int nchk = 0, npass = 0, cyc = 0;
  int mode = 0, cur_wbase = 0, cur_chunks = 1, k = 0;
  int nis = 0, fi = -1, li = -1, fr = -1, npop = 0, nlast = 0, ndone = 0;
  dpe_mvm_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rows(cmd_rows), .cmd_chunks(cmd_chunks), .cmd_wbase(cmd_wbase),
    .w_rden(w_rden), .w_raddr(w_raddr), .w_rdata(w_rdata),
    .v_rden(v_rden), .v_raddr(v_raddr), .v_rdata(v_rdata),
    .dpe_valid(dpe_valid), .dpe_dataa(dpe_dataa), .dpe_datab(dpe_datab),
    .dpe_ovalid(dpe_ovalid), .dpe_result(dpe_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // mode 4 loads the DPE result directly from the weight word to reach the wrap boundary
  function automatic logic [DATAW-1:0] wgen(int m, logic [WADDRW-1:0] a);
    logic [DATAW-1:0] x = '0;
    case (m)
      0: for (int i = 0; i < DATAW / 8; i++) x[i*8+:8] = 8'd1;
      1: x[7:0] = 8'd5;
      2: x[7:0] = {2'b00, a[5:0]};
      3: x[7:0] = 8'hF9;
      default: x[31:0] = a[0] ? 32'd1 : 32'h7FFF_FFFF;
    endcase
    return x;
  endfunction
  function automatic logic [DATAW-1:0] vgen(int m, logic [CHUNKW-1:0] c);
    logic [DATAW-1:0] x = '0;
    if (m == 0) for (int i = 0; i < DATAW / 8; i++) x[i*8+:8] = 8'd2;
    else if (m == 2) x[7:0] = 8'(c) + 8'd1;
    else x[7:0] = 8'd1;
    return x;
  endfunction
  function automatic int dot(logic [DATAW-1:0] a, logic [DATAW-1:0] b);
    int s = 0;
    for (int i = 0; i < DATAW / 8; i++) s += int'($signed(a[i*8+:8])) * int'($signed(b[i*8+:8]));
    return s;
  endfunction
  function automatic logic [OPREC-1:0] rowval(int m, int wb, int ch, int r);
    logic [OPREC-1:0] s = '0;
    logic [DATAW-1:0] w;
    for (int c = 0; c < ch; c++) begin
      w = wgen(m, WADDRW'(wb + r * ch + c));
      s += (m == 4) ? w[OPREC-1:0] : OPREC'(dot(w, vgen(m, CHUNKW'(c))));
    end
`ifdef DPE_SCHED_RELU_EN
    if (s[OPREC-1]) s = '0;
`endif
    return s;
  endfunction
  always @(posedge clk) begin
    if (w_rden) w_rdata <= wgen(mode, w_raddr);
    if (v_rden) v_rdata <= vgen(mode, v_raddr);
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DPE_LAT; i++) dpipe[i] <= '0;
    end else begin
      dpipe[0] <= {dpe_valid, (mode == 4) ? dpe_dataa[OPREC-1:0] : OPREC'(dot(dpe_dataa, dpe_datab))};
      for (int i = 1; i < DPE_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign dpe_ovalid = dpipe[DPE_LAT-1][OPREC];
  assign dpe_result = dpipe[DPE_LAT-1][OPREC-1:0];
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  always @(negedge clk) begin
    if (w_rden) begin
      chk("w_raddr", 64'(w_raddr), 64'(WADDRW'(cur_wbase + k)));
      chk("v_raddr", 64'(v_raddr), 64'(k % cur_chunks));
      k++;
      nis++;
      if (fi < 0) fi = cyc;
      li = cyc;
    end
    if (res_valid && fr < 0) fr = cyc;
    if (res_valid && res_ready) begin
      chk("res_avail", 64'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        chk("res_data", 64'(res_data), 64'(expq[0][OPREC-1:0]));
        chk("res_last", 64'(res_last), 64'(expq[0][OPREC]));
        void'(expq.pop_front());
      end
      lastres = res_data;
      npop++;
      if (res_last) nlast++;
    end
    if (done) ndone++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    nis = 0; fi = -1; li = -1; fr = -1; npop = 0; nlast = 0; ndone = 0;
  endtask
  task automatic send(int rows, int chunks, int wb, int m);
    mode = m; cur_wbase = wb; cur_chunks = (chunks > 0) ? chunks : 1; k = 0;
    for (int r = 0; r < rows && chunks > 0; r++) expq.push_back({r == rows - 1, rowval(m, wb, chunks, r)});
    cmd_valid = 1;
    cmd_rows = ROWW'(rows);
    cmd_chunks = CHUNKW'(chunks);
    cmd_wbase = WADDRW'(wb);
    for (int i = 0; i < 100 && !cmd_ready; i++) tick();
    chk("cmd_ready", 64'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
  endtask
  task automatic wait_idle(int budget);
    for (int i = 0; i < budget && (busy || expq.size() != 0); i++) tick();
    chk("idle", 64'(busy), 0);
    chk("drained", 64'(expq.size()), 0);
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_outs", 64'({cmd_ready, w_rden, v_rden, dpe_valid, res_valid, busy, done}), 64'(7'b1000000));
    rst = 0;
    tick();
    chk("pin_t1", 64'(rowval(0, 0, 1, 0)), 128);
    chk("pin_t2", 64'(rowval(1, 10, 4, 2)), 20);
    chk("pin_t3", 64'(rowval(2, 100, 1, 5)), 41);
`ifdef DPE_SCHED_RELU_EN
    chk("pin_t6", 64'(rowval(3, 0, 2, 0)), 0);
    chk("pin_wrap", 64'(rowval(4, 0, 2, 0)), 0);
`else
    chk("pin_t6", 64'(rowval(3, 0, 2, 0)), 64'hFFFF_FFF2);
    chk("pin_wrap", 64'(rowval(4, 0, 2, 0)), 64'h8000_0000);
`endif
    clr();
    send(1, 1, 0, 0);
    wait_idle(100);
    chk("t1_latency", 64'(fr - fi), 10);
    chk("t1_value", 64'(lastres), 128);
    chk("t1_last", 64'(nlast), 1);
    chk("t1_done", 64'(ndone), 1);
    clr();
    send(3, 4, 10, 1);
    wait_idle(200);
    chk("t2_issues", 64'(nis), 12);
    chk("t2_nogap", 64'(li - fi), 11);
    chk("t2_pops", 64'(npop), 3);
    chk("t2_last", 64'(nlast), 1);
    chk("t2_done", 64'(ndone), 1);
    clr();
    res_ready = 0;
    send(40, 1, 100, 2);
    repeat (60) tick();
    chk("t3_stall_issues", 64'(nis), 16);
    chk("t3_valid", 64'(res_valid), 1);
    chk("t3_busy", 64'(busy), 1);
    res_ready = 1;
    wait_idle(400);
    chk("t3_pops", 64'(npop), 40);
    chk("t3_issues", 64'(nis), 40);
    clr();
    send(0, 3, 0, 0);
    chk("t4a_done", 64'(done), 1);
    tick();
    chk("t4a_after", 64'({done, busy}), 0);
    repeat (20) tick();
    chk("t4a_reads", 64'(nis), 0);
    chk("t4a_ndone", 64'(ndone), 1);
    clr();
    send(5, 0, 0, 0);
    chk("t4b_done", 64'(done), 1);
    repeat (20) tick();
    chk("t4b_reads", 64'(nis + npop), 0);
    chk("t4b_ndone", 64'(ndone), 1);
    clr();
    send(10, 1, 0, 2);
    for (int i = 0; i < 50 && nis < 5; i++) tick();
    rst = 1;
    expq.delete();
    tick();
    chk("t5_reset_outs", 64'({cmd_ready, w_rden, v_rden, dpe_valid, res_valid, busy, done}), 64'(7'b1000000));
    repeat (10) tick();
    rst = 0;
    tick();
    clr();
    send(3, 2, 50, 2);
    wait_idle(200);
    chk("t5_pops", 64'(npop), 3);
    chk("t5_last", 64'(nlast), 1);
    chk("t5_done", 64'(ndone), 1);
    clr();
    send(2, 2, 0, 3);
    wait_idle(200);
    chk("t6_pops", 64'(npop), 2);
    clr();
    send(1, 2, 0, 4);
    wait_idle(200);
`ifdef DPE_SCHED_RELU_EN
    chk("t6_wrap", 64'(lastres), 0);
`else
    chk("t6_wrap", 64'(lastres), 64'h8000_0000);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
